// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage: NOP encoding,
// default memory depth / reset PC, IF/ID control encoding and PC wrap helper.
package fetch_stage_pkg;

    localparam int unsigned IMEM_DEPTH_DEFAULT = 512;
    localparam int unsigned RESET_PC_DEFAULT   = 0;
    localparam logic [31:0] NOP_INST           = 32'h0000_0000;

    typedef enum logic [1:0] {
        IFID_HOLD   = 2'd0,
        IFID_LOAD   = 2'd1,
        IFID_BUBBLE = 2'd2
    } ifid_ctrl_e;

    // Sequential word-index increment, wrapping at the top of instruction memory.
    function automatic logic [31:0] wrap_inc(input logic [31:0] pc, input int unsigned depth);
        return (pc == 32'(depth - 1)) ? 32'd0 : pc + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: loads a fetched instruction, holds it, or inserts a
// NOP bubble according to the control code from the fetch stage.
module ifid_reg
    import fetch_stage_pkg::*;
(
    input  logic        clock,
    input  logic        resetn,
    input  ifid_ctrl_e  ctrl,
    input  logic [31:0] inst_in,
    input  logic [31:0] pc1_in,
    output logic [31:0] inst,
    output logic [31:0] pc1,
    output logic        valid
);

    logic [31:0] inst_reg, inst_next;
    logic [31:0] pc1_reg, pc1_next;
    logic        valid_reg, valid_next;

    always_comb begin
        inst_next  = inst_reg;
        pc1_next   = pc1_reg;
        valid_next = valid_reg;
        case (ctrl)
            IFID_LOAD: begin
                inst_next  = inst_in;
                pc1_next   = pc1_in;
                valid_next = 1'b1;
            end
            IFID_BUBBLE: begin
                inst_next  = NOP_INST;
                pc1_next   = 32'd0;
                valid_next = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            inst_reg  <= NOP_INST;
            pc1_reg   <= 32'd0;
            valid_reg <= 1'b0;
        end else begin
            inst_reg  <= inst_next;
            pc1_reg   <= pc1_next;
            valid_reg <= valid_next;
        end
    end

    assign inst  = inst_reg;
    assign pc1   = pc1_reg;
    assign valid = valid_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: word-indexed PC with branch redirect and stall hold,
// IF/ID register, and a running count of valid fetches.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = IMEM_DEPTH_DEFAULT,
    parameter int unsigned RESET_PC   = RESET_PC_DEFAULT
)(
    input  logic        clock,
    input  logic        resetn,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] inst_in,
    output logic [31:0] pc_out,
    output logic [31:0] ifid_inst,
    output logic [31:0] ifid_pc1,
    output logic        ifid_valid,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] RESET_PC_W = 32'(RESET_PC % IMEM_DEPTH);

    logic [31:0] pc_reg, pc_next, pc_seq;
    logic [31:0] count_reg, count_next;
    ifid_ctrl_e  ifid_ctrl;

    assign pc_seq = wrap_inc(pc_reg, IMEM_DEPTH);

    // Redirect beats stall; a flush during a stall still squashes IF/ID.
    always_comb begin
        pc_next   = pc_seq;
        ifid_ctrl = IFID_LOAD;
        if (branch_taken) begin
            pc_next   = branch_target % IMEM_DEPTH;
            ifid_ctrl = IFID_BUBBLE;
        end else if (stall) begin
            pc_next   = pc_reg;
            ifid_ctrl = flush ? IFID_BUBBLE : IFID_HOLD;
        end else if (flush) begin
            ifid_ctrl = IFID_BUBBLE;
        end
    end

    assign count_next = (ifid_ctrl == IFID_LOAD) ? count_reg + 32'd1 : count_reg;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pc_reg    <= RESET_PC_W;
            count_reg <= 32'd0;
        end else begin
            pc_reg    <= pc_next;
            count_reg <= count_next;
        end
    end

    ifid_reg u_ifid_reg (
        .clock   (clock),
        .resetn  (resetn),
        .ctrl    (ifid_ctrl),
        .inst_in (inst_in),
        .pc1_in  (pc_seq),
        .inst    (ifid_inst),
        .pc1     (ifid_pc1),
        .valid   (ifid_valid)
    );

    assign pc_out      = pc_reg;
    assign fetch_count = count_reg;

endmodule
